// File: rtl/eq_pkg.sv
// Shared constants and FSM encoding for the equalizer band mixer and its gain stages.
package eq_pkg;
  localparam int NUM_BANDS = 10;
  localparam int DATA_W    = 24;
  localparam int GAIN_W    = 16;
  localparam int GAIN_FRAC = 14;
  localparam int ACC_W     = 44;
  localparam int PROD_W    = DATA_W + GAIN_W;
  localparam int IDX_W     = 4;
  localparam logic [GAIN_W-1:0] GAIN_RESET = 16'd16384;

  localparam int BAND_LOWPASS  = 0;
  localparam int BAND_64_125   = 1;
  localparam int BAND_125_250  = 2;
  localparam int BAND_250_500  = 3;
  localparam int BAND_500_1K   = 4;
  localparam int BAND_1K_2K    = 5;
  localparam int BAND_2K_4K    = 6;
  localparam int BAND_4K_8K    = 7;
  localparam int BAND_8K_16K   = 8;
  localparam int BAND_HIGHPASS = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;
endpackage

// File: rtl/eq_sat_round.sv
// Round-half-up of a Q.GAIN_FRAC accumulator down to DATA_W bits, with saturation.
module eq_sat_round
  import eq_pkg::*;
(
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic signed [DATA_W-1:0] sample_o,
  output logic                     sat_o
);
  localparam logic signed [ACC_W:0] HALF  = (ACC_W+1)'(2**(GAIN_FRAC-1));
  localparam logic signed [ACC_W:0] S_MAX = (ACC_W+1)'(2**(DATA_W-1)-1);
  localparam logic signed [ACC_W:0] S_MIN = (ACC_W+1)'(-(2**(DATA_W-1)));

  logic signed [ACC_W:0] biased;
  logic signed [ACC_W:0] rounded;

  always_comb begin
    // One guard bit so the rounding bias can never wrap the accumulator.
    biased   = (ACC_W+1)'(acc_i) + HALF;
    rounded  = biased >>> GAIN_FRAC;
    sat_o    = 1'b0;
    sample_o = rounded[DATA_W-1:0];
    if (rounded > S_MAX) begin
      sample_o = S_MAX[DATA_W-1:0];
      sat_o    = 1'b1;
    end else if (rounded < S_MIN) begin
      sample_o = S_MIN[DATA_W-1:0];
      sat_o    = 1'b1;
    end
  end
endmodule

// File: rtl/eq_band_mixer.sv
// Per-band gain and sum of the ten filter bands through one shared multiplier,
// sequenced by a small IDLE/MAC/OUT FSM.
module eq_band_mixer
  import eq_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic                        sample_valid,
  input  logic [NUM_BANDS*DATA_W-1:0] band_in,
  input  logic                        gain_wr_en,
  input  logic [IDX_W-1:0]            gain_addr,
  input  logic [GAIN_W-1:0]           gain_data,
  output logic [DATA_W-1:0]           audio_out,
  output logic                        out_valid,
  output logic                        busy,
  output logic                        sat_flag,
  output logic                        overrun
);
  state_e                               state_q, state_d;
  logic [IDX_W-1:0]                     idx_q, idx_d;
  logic signed [ACC_W-1:0]              acc_q, acc_d;
  logic [NUM_BANDS-1:0][DATA_W-1:0]     band_q, band_d;
  logic [NUM_BANDS-1:0][GAIN_W-1:0]     gain_q, gain_d;
  logic [NUM_BANDS-1:0][GAIN_W-1:0]     shadow_q, shadow_d;
  logic [DATA_W-1:0]                    audio_q, audio_d;
  logic                                 out_valid_q, out_valid_d;
  logic                                 sat_q, sat_d;
  logic                                 overrun_q, overrun_d;

  logic signed [PROD_W-1:0] prod;
  logic signed [DATA_W-1:0] rnd_sample;
  logic                     rnd_sat;

  eq_sat_round u_sat_round (
    .acc_i    (acc_q),
    .sample_o (rnd_sample),
    .sat_o    (rnd_sat)
  );

  // Live bank takes writes at any time; out-of-range addresses match no band.
  always_comb begin
    gain_d = gain_q;
    for (int k = 0; k < NUM_BANDS; k++)
      if (gain_wr_en && gain_addr == IDX_W'(k)) gain_d[k] = gain_data;
  end

  always_comb begin
    prod        = $signed(band_q[idx_q]) * $signed(shadow_q[idx_q]);
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    band_d      = band_q;
    shadow_d    = shadow_q;
    audio_d     = audio_q;
    out_valid_d = 1'b0;
    sat_d       = sat_q;
    overrun_d   = overrun_q | (sample_valid && state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: if (enable && sample_valid) begin
        band_d   = band_in;
        shadow_d = gain_q;
        acc_d    = '0;
        idx_d    = '0;
        state_d  = ST_MAC;
      end
      ST_MAC: if (enable) begin
        acc_d = acc_q + ACC_W'(prod);
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(NUM_BANDS-1)) begin
          idx_d   = '0;
          state_d = ST_OUT;
        end
      end
      ST_OUT: if (enable) begin
        audio_d     = rnd_sample;
        sat_d       = sat_q | rnd_sat;
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      band_q      <= '0;
      gain_q      <= {NUM_BANDS{GAIN_RESET}};
      shadow_q    <= {NUM_BANDS{GAIN_RESET}};
      audio_q     <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      band_q      <= band_d;
      gain_q      <= gain_d;
      shadow_q    <= shadow_d;
      audio_q     <= audio_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
      overrun_q   <= overrun_d;
    end
  end

  assign audio_out = audio_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign sat_flag  = sat_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_eq_band_mixer.sv
// Self-checking bench for eq_band_mixer: directed table, random mixes against an
// integer reference model, and hand-written multi-cycle corner sequences.
module tb_eq_band_mixer;
  localparam int NB = 10;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           enable;
  logic           sample_valid;
  logic [NB*24-1:0] band_in;
  logic           gain_wr_en;
  logic [3:0]     gain_addr;
  logic [15:0]    gain_data;
  logic [23:0]    audio_out;
  logic           out_valid, busy, sat_flag, overrun;

  int checks = 0;
  int errors = 0;

  eq_band_mixer dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sample_valid(sample_valid),
    .band_in(band_in), .gain_wr_en(gain_wr_en), .gain_addr(gain_addr),
    .gain_data(gain_data), .audio_out(audio_out), .out_valid(out_valid),
    .busy(busy), .sat_flag(sat_flag), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NB*24-1:0] bands;
    logic [NB*16-1:0] gains;
    longint           exp_audio;
    bit               exp_sat;
  } vec_t;

  vec_t vt[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic write_gain(input int band, input logic [15:0] g);
    gain_wr_en = 1'b1;
    gain_addr  = 4'(band);
    gain_data  = g;
    tick();
    gain_wr_en = 1'b0;
  endtask

  task automatic set_gains(input logic [NB*16-1:0] g);
    for (int k = 0; k < NB; k++) write_gain(k, g[k*16 +: 16]);
  endtask

  // Strobes one sample, then waits (bounded) for the output pulse.
  task automatic mix(input logic [NB*24-1:0] b, output longint val, output int lat);
    band_in      = b;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    val = longint'($signed(audio_out));
  endtask

  // Reference: exact integer dot product, round half up, clamp to 24 bits.
  function automatic void model(input logic [NB*24-1:0] b, input logic [NB*16-1:0] g,
                                output longint r, output bit s);
    longint sum = 0;
    for (int k = 0; k < NB; k++)
      sum += longint'($signed(b[k*24 +: 24])) * longint'($signed(g[k*16 +: 16]));
    r = (sum + 8192) >>> 14;
    s = 1'b0;
    if (r > 8388607)  begin r = 8388607;  s = 1'b1; end
    if (r < -8388608) begin r = -8388608; s = 1'b1; end
  endfunction

  initial begin
    longint val, er;
    int lat, pulses;
    bit es, msat;
    logic [NB*24-1:0] b;
    logic [NB*16-1:0] g;
    logic signed [23:0] bv;

    reset_n = 1'b0; enable = 1'b1; sample_valid = 1'b0; band_in = '0;
    gain_wr_en = 1'b0; gain_addr = '0; gain_data = '0;
    repeat (3) tick();
    chk("reset_audio", longint'(audio_out), 0);
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_busy", longint'(busy), 0);
    chk("reset_sat", longint'(sat_flag), 0);
    chk("reset_overrun", longint'(overrun), 0);
    reset_n = 1'b1;
    tick();

    vt[0] = '{ {NB{24'd1000}}, {NB{16'd16384}}, 10000, 1'b0 };
    vt[1] = '{ {{9{24'd0}}, 24'd3}, {{9{16'd0}}, 16'd8192}, 2, 1'b0 };
    vt[2] = '{ {{9{24'd0}}, 24'hFFFFFD}, {{9{16'd0}}, 16'd8192}, -1, 1'b0 };
    vt[3] = '{ {NB{24'h7FFFFF}}, {NB{16'd16384}}, 8388607, 1'b1 };
    vt[4] = '{ {NB{24'h800000}}, {NB{16'd16384}}, -8388608, 1'b1 };

    for (int i = 0; i < 5; i++) begin
      set_gains(vt[i].gains);
      mix(vt[i].bands, val, lat);
      chk($sformatf("vec%0d_latency", i), lat, 11);
      chk($sformatf("vec%0d_audio", i), val, vt[i].exp_audio);
      chk($sformatf("vec%0d_sat", i), longint'(sat_flag), longint'(vt[i].exp_sat));
      tick();
      chk($sformatf("vec%0d_pulse", i), longint'(out_valid), 0);
    end

    msat = 1'b1;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < NB; k++) begin
        bv = 24'($urandom);
        bv = bv >>> $urandom_range(0, 12);
        b[k*24 +: 24] = bv;
        g[k*16 +: 16] = 16'($urandom);
      end
      set_gains(g);
      model(b, g, er, es);
      msat |= es;
      mix(b, val, lat);
      chk($sformatf("rand%0d_latency", i), lat, 11);
      chk($sformatf("rand%0d_audio", i), val, er);
      chk($sformatf("rand%0d_sat", i), longint'(sat_flag), longint'(msat));
    end

    // Second strobe five cycles into a mix is dropped.
    set_gains({NB{16'd16384}});
    band_in = {NB{24'd1000}};
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    repeat (4) tick();
    band_in = {NB{24'd7}};
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    pulses = 0; val = 0;
    for (int n = 0; n < 20; n++) begin
      if (out_valid) begin
        pulses++;
        if (pulses == 1) val = longint'($signed(audio_out));
      end
      tick();
    end
    chk("overrun_pulses", pulses, 1);
    chk("overrun_audio", val, 10000);
    chk("overrun_flag", longint'(overrun), 1);
    mix({NB{24'd2}}, val, lat);
    chk("after_overrun_latency", lat, 11);
    chk("after_overrun_audio", val, 20);

    // Gain write during a mix only affects the following mix.
    b = '0;
    b[9*24 +: 24] = 24'd5000;
    band_in = b;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    tick(); tick();
    write_gain(9, 16'hC000);
    lat = 3;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    chk("shadow_old_gain", longint'($signed(audio_out)), 5000);
    tick();
    mix(b, val, lat);
    chk("shadow_new_gain", val, -5000);
    write_gain(12, 16'd0);
    mix({NB{24'd1000}}, val, lat);
    chk("bad_addr_ignored", val, 8000);

    // Enable low for four cycles stretches the latency by four.
    band_in = {NB{24'd1000}};
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    lat = 0;
    repeat (3) begin tick(); lat++; end
    enable = 1'b0;
    pulses = 0;
    repeat (4) begin tick(); lat++; if (out_valid) pulses++; end
    chk("stall_busy", longint'(busy), 1);
    chk("stall_no_pulse", pulses, 0);
    enable = 1'b1;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    chk("stall_latency", lat, 15);
    chk("stall_audio", longint'($signed(audio_out)), 8000);
    tick();

    // Reset in the middle of a mix discards it.
    band_in = {NB{24'd1000}};
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    repeat (4) tick();
    reset_n = 1'b0;
    #2;
    chk("midreset_audio", longint'(audio_out), 0);
    chk("midreset_busy", longint'(busy), 0);
    chk("midreset_sat", longint'(sat_flag), 0);
    chk("midreset_overrun", longint'(overrun), 0);
    tick();
    reset_n = 1'b1;
    enable = 1'b0;
    band_in = {NB{24'd1000}};
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    enable = 1'b1;
    pulses = 0;
    for (int n = 0; n < 20; n++) begin
      if (out_valid) pulses++;
      tick();
    end
    chk("midreset_no_pulse", pulses, 0);
    chk("disabled_strobe_no_overrun", longint'(overrun), 0);
    mix({NB{24'd1000}}, val, lat);
    chk("post_reset_latency", lat, 11);
    chk("post_reset_gains", val, 10000);
    chk("post_reset_sat", longint'(sat_flag), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
